// File: rtl/fx2_slave_fifo_master.sv
// Synchronous slave-FIFO master for the Cypress FX2: moves bytes from EP2 onto rx_* and
// from tx_* into EP6, alternating direction in bursts of at most BURST_MAX bytes.
module fx2_slave_fifo_master #(
   parameter int BURST_MAX = 64
) (
   input  logic       clk0,
   input  logic       reset,
   input  logic       usb_flaga,
   input  logic       usb_flagc,
   output logic [1:0] usb_addr,
   input  logic [7:0] usb_data_in,
   output logic [7:0] usb_data_out,
   output logic       usb_data_oe,
   output logic       usb_slcs,
   output logic       usb_sloe,
   output logic       usb_slrd,
   output logic       usb_slwr,
   output logic       usb_pktend,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       tx_flush,
   output logic [2:0] state_dbg
);

   // Handshakes: a byte moves on rx_* / tx_* at the rising edge where valid and ready are
   // both 1; a valid source holds its data stable until that edge.
   typedef enum logic [2:0] {IDLE, RD_SEL, RD, WR_SEL, WR, PKTEND} state_t;

   localparam logic [9:0] BURST_LIM = 10'(BURST_MAX);

   state_t     state, state_next;
   logic [9:0] burst_cnt;
   logic       flush_pending;
   logic       last_rd;
   logic       rd_req, wr_req;
   logic       rd_strobe, wr_strobe;

   assign state_dbg = state;
   assign usb_slcs  = reset;

   always_comb begin
      rd_req       = usb_flaga & (~rx_valid | rx_ready);
      wr_req       = (tx_valid & usb_flagc) | flush_pending;
      state_next   = state;
      rd_strobe    = 1'b0;
      wr_strobe    = 1'b0;
      usb_addr     = 2'b00;
      usb_sloe     = 1'b1;
      usb_slrd     = 1'b1;
      usb_slwr     = 1'b1;
      usb_pktend   = 1'b1;
      usb_data_oe  = 1'b0;
      usb_data_out = 8'h00;
      tx_ready     = 1'b0;
      case (state)
         IDLE: begin
            // On contention the direction served last yields.
            if (rd_req && !(wr_req && last_rd)) state_next = RD_SEL;
            else if (wr_req)                    state_next = WR_SEL;
         end
         RD_SEL: begin
            usb_sloe   = 1'b0;
            state_next = RD;
         end
         RD: begin
            usb_sloe  = 1'b0;
            rd_strobe = rd_req;
            usb_slrd  = ~rd_strobe;
            if (!rd_strobe || burst_cnt >= BURST_LIM - 10'd1) state_next = IDLE;
         end
         WR_SEL: begin
            usb_addr    = 2'b10;
            usb_data_oe = 1'b1;
            state_next  = (!tx_valid && flush_pending) ? PKTEND : WR;
         end
         WR: begin
            usb_addr     = 2'b10;
            usb_data_oe  = 1'b1;
            tx_ready     = usb_flagc;
            wr_strobe    = tx_valid & usb_flagc;
            usb_slwr     = ~wr_strobe;
            usb_data_out = wr_strobe ? tx_data : 8'h00;
            if (!usb_flagc)                              state_next = IDLE;
            else if (!tx_valid)                          state_next = flush_pending ? PKTEND : IDLE;
            else if (burst_cnt >= BURST_LIM - 10'd1)     state_next = IDLE;
         end
         PKTEND: begin
            usb_addr    = 2'b10;
            usb_data_oe = 1'b1;
            usb_pktend  = 1'b0;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Reset silences the bus in the very cycle it is asserted.
      if (reset) begin
         state_next   = IDLE;
         rd_strobe    = 1'b0;
         wr_strobe    = 1'b0;
         usb_addr     = 2'b00;
         usb_sloe     = 1'b1;
         usb_slrd     = 1'b1;
         usb_slwr     = 1'b1;
         usb_pktend   = 1'b1;
         usb_data_oe  = 1'b0;
         usb_data_out = 8'h00;
         tx_ready     = 1'b0;
      end
   end

   always_ff @(posedge clk0) begin
      if (reset) begin
         state         <= IDLE;
         burst_cnt     <= 10'd0;
         flush_pending <= 1'b0;
         last_rd       <= 1'b0;
         rx_valid      <= 1'b0;
         rx_data       <= 8'h00;
      end else begin
         state <= state_next;
         if (state_next == RD_SEL || state_next == WR_SEL)
            burst_cnt <= 10'd0;
         else if ((rd_strobe || wr_strobe) && burst_cnt != BURST_LIM)
            burst_cnt <= burst_cnt + 10'd1;
         if (state_next == RD_SEL)      last_rd <= 1'b1;
         else if (state_next == WR_SEL) last_rd <= 1'b0;
         // A flush arriving in the PKTEND cycle itself stays armed for the next packet.
         flush_pending <= tx_flush | (flush_pending & (state != PKTEND));
         if (rd_strobe) begin
            rx_data  <= usb_data_in;
            rx_valid <= 1'b1;
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fx2_slave_fifo_master.sv
// Bench for fx2_slave_fifo_master: FX2 FIFO models on the bus side, byte streams on the
// user side, and a per-cycle reference of the bus rules checked at every falling edge.
module tb_fx2_slave_fifo_master;

   localparam int BM = 64;
   localparam int K_IDLE = 0, K_RSEL = 1, K_RD = 2, K_WSEL = 3, K_WR = 4, K_PKT = 5;
   localparam int WIN_R = 1, WIN_W = 2;

   logic       clk0 = 1'b0;
   logic       reset;
   logic       usb_flaga, usb_flagc;
   logic [1:0] usb_addr;
   logic [7:0] usb_data_in, usb_data_out;
   logic       usb_data_oe, usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_pktend;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready, tx_flush;
   logic [2:0] state_dbg;

   always #5 clk0 = ~clk0;

   fx2_slave_fifo_master #(.BURST_MAX(BM)) dut (
      .clk0(clk0), .reset(reset), .usb_flaga(usb_flaga), .usb_flagc(usb_flagc),
      .usb_addr(usb_addr), .usb_data_in(usb_data_in), .usb_data_out(usb_data_out),
      .usb_data_oe(usb_data_oe), .usb_slcs(usb_slcs), .usb_sloe(usb_sloe),
      .usb_slrd(usb_slrd), .usb_slwr(usb_slwr), .usb_pktend(usb_pktend),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flush(tx_flush),
      .state_dbg(state_dbg)
   );

   int total = 0, bad = 0;
   logic [7:0] ep2_q[$], src_q[$], rx_got[$], ep6_got[$];
   logic [7:0] exp_q[$], exp_tx_q[$];
   int win_kind[$], win_str[$];
   int cur_kind, cur_str, pkt_cnt, wr_cnt, cyc, last_wr_cyc, pkt_cyc;
   int m_kind, bc;
   bit m_last_rd, m_flush, m_rx_full, rst_prev;
   logic [7:0] m_rx_byte;
   bit rnd, rx_rdy_v, flaga_en, flagc_en, txv_en;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   // Reference: predicts the bus class of each cycle from the rules of the interface.
   task automatic check_cycle();
      logic [1:0] e_addr;
      logic       e_sloe, e_slrd, e_slwr, e_pkt, e_oe, e_txr;
      logic [7:0] e_dout;
      bit         rd_req, wr_req, rds, wrs;
      int         nk;
      cyc++;
      if (reset) begin
         chk("rst_slcs", usb_slcs, 1);     chk("rst_sloe", usb_sloe, 1);
         chk("rst_slrd", usb_slrd, 1);     chk("rst_slwr", usb_slwr, 1);
         chk("rst_pktend", usb_pktend, 1); chk("rst_addr", usb_addr, 0);
         chk("rst_dout", usb_data_out, 0); chk("rst_oe", usb_data_oe, 0);
         chk("rst_txready", tx_ready, 0);
         if (rst_prev) begin
            chk("rst_rxvalid", rx_valid, 0);
            chk("rst_rxdata", rx_data, 0);
         end
         m_kind = K_IDLE; bc = 0; m_last_rd = 0; m_flush = 0; m_rx_full = 0;
         cur_kind = 0; rst_prev = 1;
         return;
      end
      rst_prev = 0;
      rd_req = usb_flaga && (!m_rx_full || rx_ready);
      wr_req = (tx_valid && usb_flagc) || m_flush;
      e_addr = 2'b00; e_sloe = 1; e_slrd = 1; e_slwr = 1; e_pkt = 1; e_oe = 0; e_txr = 0;
      e_dout = 8'h00; nk = K_IDLE; rds = 0; wrs = 0;
      case (m_kind)
         K_IDLE: begin
            if (rd_req && (!wr_req || !m_last_rd)) nk = K_RSEL;
            else if (wr_req)                       nk = K_WSEL;
         end
         K_RSEL: begin e_sloe = 0; bc = 0; nk = K_RD; end
         K_RD: begin
            e_sloe = 0; rds = rd_req; e_slrd = !rds;
            if (rds) bc++;
            nk = (rds && bc < BM) ? K_RD : K_IDLE;
         end
         K_WSEL: begin
            e_addr = 2'b10; e_oe = 1; bc = 0;
            nk = (!tx_valid && m_flush) ? K_PKT : K_WR;
         end
         K_WR: begin
            e_addr = 2'b10; e_oe = 1; e_txr = usb_flagc;
            wrs = tx_valid && usb_flagc; e_slwr = !wrs;
            if (wrs) begin e_dout = tx_data; bc++; end
            if (!usb_flagc)     nk = K_IDLE;
            else if (!tx_valid) nk = m_flush ? K_PKT : K_IDLE;
            else                nk = (bc < BM) ? K_WR : K_IDLE;
         end
         default: begin e_addr = 2'b10; e_oe = 1; e_pkt = 0; nk = K_IDLE; end
      endcase
      chk("slcs", usb_slcs, 0);        chk("addr", usb_addr, e_addr);
      chk("sloe", usb_sloe, e_sloe);   chk("slrd", usb_slrd, e_slrd);
      chk("slwr", usb_slwr, e_slwr);   chk("pktend", usb_pktend, e_pkt);
      chk("oe", usb_data_oe, e_oe);    chk("tx_ready", tx_ready, e_txr);
      chk("dout", usb_data_out, e_dout);
      chk("rx_valid", rx_valid, m_rx_full);
      if (m_rx_full) chk("rx_data", rx_data, m_rx_byte);
      // Environment reacts to what the DUT actually drove.
      if (m_kind == K_RSEL) begin cur_kind = WIN_R; cur_str = 0; end
      if (m_kind == K_WSEL) begin cur_kind = WIN_W; cur_str = 0; end
      if (!usb_slrd || !usb_slwr) cur_str++;
      if (!usb_slrd && ep2_q.size() > 0) void'(ep2_q.pop_front());
      if (rx_valid && rx_ready) rx_got.push_back(rx_data);
      if (tx_valid && tx_ready && src_q.size() > 0) void'(src_q.pop_front());
      if (!usb_slwr) begin ep6_got.push_back(usb_data_out); wr_cnt++; last_wr_cyc = cyc; end
      if (!usb_pktend) begin pkt_cnt++; pkt_cyc = cyc; end
      if (m_kind != K_IDLE && nk == K_IDLE && cur_kind != 0) begin
         win_kind.push_back(cur_kind); win_str.push_back(cur_str); cur_kind = 0;
      end
      if (rds) begin m_rx_full = 1; m_rx_byte = usb_data_in; end
      else if (rx_ready) m_rx_full = 0;
      if (nk == K_RSEL)      m_last_rd = 1;
      else if (nk == K_WSEL) m_last_rd = 0;
      m_flush = tx_flush || (m_flush && m_kind != K_PKT);
      m_kind = nk;
   endtask

   task automatic drive_inputs();
      logic [7:0] b;
      if (rnd) begin
         flaga_en = $urandom_range(0, 9) < 9;
         flagc_en = $urandom_range(0, 9) < 8;
         txv_en   = $urandom_range(0, 9) < 7;
         rx_ready = $urandom_range(0, 9) < 7;
         tx_flush = $urandom_range(0, 63) == 0;
         if (ep2_q.size() < 4 && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 40)) begin
               b = 8'($urandom); ep2_q.push_back(b); exp_q.push_back(b);
            end
         if (src_q.size() < 4 && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 80)) begin
               b = 8'($urandom); src_q.push_back(b); exp_tx_q.push_back(b);
            end
      end else begin
         rx_ready = rx_rdy_v;
         tx_flush = 1'b0;
      end
      usb_flaga   = (ep2_q.size() > 0) && flaga_en;
      usb_data_in = (ep2_q.size() > 0) ? ep2_q[0] : 8'($urandom);
      usb_flagc   = flagc_en;
      tx_valid    = (src_q.size() > 0) && (tx_valid || txv_en);
      tx_data     = (src_q.size() > 0) ? src_q[0] : 8'h00;
   endtask

   task automatic tick();
      @(negedge clk0);
      check_cycle();
      @(posedge clk0);
      #1;
      drive_inputs();
   endtask

   task automatic wait_idle(input string name);
      int quiet = 0, n = 0;
      while (quiet < 3 && n < 3000) begin
         tick(); n++;
         if (ep2_q.size() == 0 && src_q.size() == 0 && !m_flush && m_kind == K_IDLE &&
             !m_rx_full && !tx_valid && !tx_flush) quiet++;
         else quiet = 0;
      end
      chk({name, "_drained"}, int'(quiet >= 3), 1);
   endtask

   task automatic clear_stats();
      win_kind.delete(); win_str.delete(); rx_got.delete(); ep6_got.delete();
      pkt_cnt = 0; wr_cnt = 0; last_wr_cyc = 0; pkt_cyc = 0;
   endtask

   initial begin
      int n, errs, maxs;
      reset = 1; tx_valid = 0; tx_flush = 0; rx_ready = 1; rx_rdy_v = 1;
      flaga_en = 1; flagc_en = 1; txv_en = 1; rnd = 0;
      m_kind = K_IDLE; bc = 0; cyc = 0; cur_kind = 0; rst_prev = 0;
      clear_stats();
      drive_inputs();
      repeat (3) tick();

      // Both directions requesting straight out of reset: read wins, then write.
      ep2_q = {8'h01, 8'h02, 8'h03, 8'h04};
      src_q = {8'h81, 8'h82, 8'h83, 8'h84};
      tick();
      reset = 0;
      wait_idle("t31");
      chk("t31_first", qget(win_kind, 0), WIN_R);
      chk("t31_second", qget(win_kind, 1), WIN_W);
      chk("t31_rx_n", rx_got.size(), 4);
      chk("t31_tx_n", ep6_got.size(), 4);

      // Three-byte EP2 read.
      clear_stats();
      ep2_q = {8'h11, 8'h22, 8'h33};
      wait_idle("t29");
      chk("t29_wins", win_kind.size(), 1);
      chk("t29_strobes", qget(win_str, 0), 3);
      chk("t29_b0", rx_got.size() > 0 ? int'(rx_got[0]) : -1, 'h11);
      chk("t29_b1", rx_got.size() > 1 ? int'(rx_got[1]) : -1, 'h22);
      chk("t29_b2", rx_got.size() > 2 ? int'(rx_got[2]) : -1, 'h33);

      // Consumer stalls after the first byte.
      clear_stats();
      rx_rdy_v = 0;
      ep2_q = {8'hA5, 8'hB6, 8'hC7};
      repeat (10) tick();
      chk("t32_hold_valid", rx_valid, 1);
      chk("t32_hold_data", rx_data, 'hA5);
      chk("t32_one_strobe", qget(win_str, 0), 1);
      chk("t32_one_win", win_kind.size(), 1);
      rx_rdy_v = 1;
      wait_idle("t32");
      chk("t32_n", rx_got.size(), 3);
      chk("t32_last", rx_got.size() > 2 ? int'(rx_got[2]) : -1, 'hC7);

      // 70-byte write splits into 64 + 6.
      clear_stats();
      for (int i = 0; i < 70; i++) src_q.push_back(8'(i * 3 + 1));
      wait_idle("t30");
      chk("t30_burst0", qget(win_str, 0), 64);
      chk("t30_burst1", qget(win_str, 1), 6);
      chk("t30_n", ep6_got.size(), 70);
      errs = 0;
      for (int i = 0; i < ep6_got.size(); i++) if (ep6_got[i] != 8'(i * 3 + 1)) errs++;
      chk("t30_stream", errs, 0);

      // Short packet commit, then a zero-length packet.
      clear_stats();
      src_q = {8'h5A, 8'h5B, 8'h5C};
      n = 0;
      while (src_q.size() > 0 && n < 100) begin tick(); n++; end
      tx_flush = 1;
      wait_idle("t33");
      chk("t33_writes", wr_cnt, 3);
      chk("t33_pktend", pkt_cnt, 1);
      chk("t33_order", int'(pkt_cyc > last_wr_cyc), 1);
      clear_stats();
      tx_flush = 1;
      wait_idle("t33z");
      chk("t33z_pktend", pkt_cnt, 1);
      chk("t33z_writes", wr_cnt, 0);

      // Reset in the middle of a write burst.
      clear_stats();
      for (int i = 0; i < 20; i++) src_q.push_back(8'(8'hC0 + i));
      n = 0;
      while (wr_cnt < 4 && n < 200) begin tick(); n++; end
      reset = 1;
      tick();
      reset = 0;
      #1;
      chk("t34_slwr", usb_slwr, 1);
      chk("t34_oe", usb_data_oe, 0);
      chk("t34_txready", tx_ready, 0);
      wait_idle("t34");
      chk("t34_n", ep6_got.size(), 20);
      errs = 0;
      for (int i = 0; i < ep6_got.size(); i++) if (ep6_got[i] != 8'(8'hC0 + i)) errs++;
      chk("t34_stream", errs, 0);

      // Randomized traffic in both directions.
      clear_stats();
      exp_q.delete(); exp_tx_q.delete();
      rnd = 1;
      repeat (2500) tick();
      rnd = 0; flaga_en = 1; flagc_en = 1; txv_en = 1; rx_rdy_v = 1;
      wait_idle("rnd");
      chk("rnd_rx_n", rx_got.size(), exp_q.size());
      chk("rnd_tx_n", ep6_got.size(), exp_tx_q.size());
      errs = 0;
      for (int i = 0; i < rx_got.size() && i < exp_q.size(); i++)
         if (rx_got[i] != exp_q[i]) errs++;
      for (int i = 0; i < ep6_got.size() && i < exp_tx_q.size(); i++)
         if (ep6_got[i] != exp_tx_q[i]) errs++;
      chk("rnd_streams", errs, 0);
      maxs = 0;
      foreach (win_str[i]) if (win_str[i] > maxs) maxs = win_str[i];
      chk("rnd_burst_max", int'(maxs <= BM), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule

// File: doc/fx2_slave_fifo_master.md
FX2_SLAVE_FIFO_MASTER -- requirements
Module: fx2_slave_fifo_master

Interface
REQ-001 SHALL have parameter BURST_MAX, default 64: max bytes moved in one direction before re-arbitration (range 1..512).
REQ-002 SHALL have port clk0  in  1  interface clock (FX2 IFCLK domain); all logic on rising edge.
REQ-003 SHALL have port reset  in  1  reset: synchronous, active-high.
REQ-004 SHALL have port usb_flaga  in  1  EP2 (host->FPGA) not-empty flag; 1 = data available.
REQ-005 SHALL have port usb_flagc  in  1  EP6 (FPGA->host) not-full flag; 1 = space available.
REQ-006 SHALL have port usb_addr  out  2  FIFO select: 2'b00 = EP2, 2'b10 = EP6.
REQ-007 SHALL have ports usb_data_in  in  8 / usb_data_out  out  8 / usb_data_oe  out  1: split tristate data bus; top level drives usb_data when usb_data_oe=1.
REQ-008 SHALL have ports usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_pktend  out  1 each: FX2 strobes, active-low.
REQ-009 SHALL have ports rx_data  out  8, rx_valid  out  1, rx_ready  in  1: host->FPGA byte stream, valid/ready.
REQ-010 SHALL have ports tx_data  in  8, tx_valid  in  1, tx_ready  out  1: FPGA->host byte stream, valid/ready.
REQ-011 SHALL have port tx_flush  in  1: single-cycle request to commit a short EP6 packet.

Function
REQ-012 SHALL implement FSM states IDLE, RD_SEL, RD, WR_SEL, WR, PKTEND.
REQ-013 IDLE: usb_sloe=1, usb_data_oe=0, all strobes high; IDLE lasts >=1 cycle between any two bursts (bus turnaround).
REQ-014 Arbitration from IDLE: rd_req = usb_flaga & rx output register free; wr_req = (tx_valid & usb_flagc) | flush_pending; if both, grant direction NOT served last; else grant requester; else stay IDLE.
REQ-015 RD_SEL: usb_addr=00, usb_sloe=0, no strobe; exactly 1 cycle, then RD.
REQ-016 RD: usb_slrd=0 in a cycle iff usb_flaga=1 and (rx_valid=0 or rx_ready=1); at that edge rx_data<=usb_data_in, rx_valid<=1; throughput 1 byte/cycle.
REQ-017 rx_valid SHALL clear on edge where rx_ready=1 and no new byte loads; rx_data stable while rx_valid=1 & rx_ready=0.
REQ-018 RD exits to IDLE when usb_flaga=0, or BURST_MAX bytes read, or rx stalled (rx_valid=1 & rx_ready=0); usb_sloe returns to 1 in IDLE.
REQ-019 WR_SEL: usb_addr=10, usb_data_oe=1, usb_slwr=1; exactly 1 cycle, then WR (or PKTEND if tx_valid=0 and flush_pending).
REQ-020 WR: tx_ready = usb_flagc (combinational, 0 in all other states); usb_slwr=0 and usb_data_out=tx_data in a cycle iff tx_valid & tx_ready.
REQ-021 WR exits when usb_flagc=0 or BURST_MAX bytes written -> IDLE; when tx_valid=0: to PKTEND if flush_pending, else IDLE.
REQ-022 flush_pending SHALL set on tx_flush=1 in any state, clear on leaving PKTEND; tx_flush coinciding with PKTEND exit re-arms it (not lost).
REQ-023 PKTEND: usb_addr=10, usb_pktend=0, usb_slwr=1 for exactly 1 cycle, then IDLE; PKTEND with zero bytes since last commit SHALL still be issued (ZLP).
REQ-024 Burst byte counter SHALL be 10 bits, cleared on entering RD_SEL/WR_SEL, saturating at BURST_MAX.
REQ-025 usb_slrd and usb_slwr SHALL never be low in the same cycle; usb_data_oe=1 only in WR_SEL/WR/PKTEND.

Reset
REQ-026 While reset=1: state=IDLE, usb_slcs=1, usb_sloe=1, usb_slrd=1, usb_slwr=1, usb_pktend=1, usb_addr=00, usb_data_out=0, usb_data_oe=0, rx_valid=0, rx_data=0, tx_ready=0, flush_pending=0, counter=0, last-served=WR (so first contention grants RD).
REQ-027 usb_slcs SHALL be 0 from first cycle after reset deasserts.
REQ-028 Reset mid-burst SHALL abort immediately, no further strobes; a partially buffered rx byte is discarded.

Verification
REQ-029 EP2 model holds 0x11,0x22,0x33, rx_ready=1 -> RD_SEL 1 cycle, 3 consecutive slrd low cycles, rx_data sequence 11,22,33, then IDLE.
REQ-030 tx_valid with 70 bytes, flagc=1, BURST_MAX=64 -> 64 slwr pulses, IDLE>=1 cycle, WR_SEL, 6 more pulses; no byte lost or duplicated.
REQ-031 flaga=1 and tx_valid=1 simultaneously from reset -> RD granted first; after RD exit next grant is WR; sloe=1 and data_oe=0 in intervening IDLE.
REQ-032 rx_ready=0 after first byte 0xA5 -> rx_data holds A5, no further slrd, RD exits to IDLE; rx_ready=1 resumes reads.
REQ-033 Write 3 bytes then tx_flush=1 with tx_valid=0 -> one pktend low cycle with addr=10 after last slwr; tx_flush alone from idle -> ZLP pktend.
REQ-034 reset asserted during WR at byte 5 -> next cycle all strobes high, data_oe=0, tx_ready=0; recovery arbitrates normally.
